// File: rtl/led_breath_pwm.sv
// led_breath_pwm: breathing LED driver (ramp up, hold, ramp down, hold).
// Ports: CLK100MHZ, RST (async high), en, LED, duty, phase, period_done.
module led_breath_pwm #(
  parameter int PWM_BITS     = 8,
  parameter int STEP_PERIODS = 1,
  parameter int HOLD_PERIODS = 16
) (
  input  logic                CLK100MHZ,
  input  logic                RST,
  input  logic                en,
  output logic                LED,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase,
  output logic                period_done
);

  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [PWM_BITS-1:0] MAX   = '1;
  localparam logic [PWM_BITS-1:0] TOP   = MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] ONE   = PWM_BITS'(1);
  localparam logic [SW-1:0]  STEP_LAST  = SW'(STEP_PERIODS - 1);
  localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_PERIODS - 1);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    HOLD_HI = 2'd1,
    DOWN    = 2'd2,
    HOLD_LO = 2'd3
  } phase_e;

  phase_e              phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [PWM_BITS-1:0] duty_q;
  logic [SW-1:0]       step_q;
  logic [HW-1:0]       hold_q;
  logic                led_q;
  logic                pd_q;

  logic pe;
  logic se;
  logic hold_end;
  logic in_hold;
  logic duty_inc;
  logic duty_dec;
  logic hold_adv;
  logic phase_chg;

  // Period end, step event, and hold expiry all qualify on en via pe,
  // so every counter below freezes automatically while en is low.
  assign pe       = en & (pwm_q == MAX);
  assign se       = pe & (step_q == STEP_LAST);
  assign hold_end = pe & (hold_q == HOLD_LAST);

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      phase_q <= UP;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Transitions fire on the same step that reaches the endpoint,
  // which is what keeps duty from ever wrapping.
  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      UP:      if (se && duty_q == TOP) phase_d = HOLD_HI;
      HOLD_HI: if (hold_end)            phase_d = DOWN;
      DOWN:    if (se && duty_q == ONE) phase_d = HOLD_LO;
      HOLD_LO: if (hold_end)            phase_d = UP;
      default:                          phase_d = UP;
    endcase
  end

  always_comb begin
    in_hold   = (phase_q == HOLD_HI) | (phase_q == HOLD_LO);
    duty_inc  = se & (phase_q == UP);
    duty_dec  = se & (phase_q == DOWN);
    hold_adv  = pe & in_hold;
    phase_chg = (phase_d != phase_q);
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      pwm_q  <= '0;
      duty_q <= '0;
      step_q <= '0;
      hold_q <= '0;
      led_q  <= 1'b0;
      pd_q   <= 1'b0;
    end else begin
      led_q <= en & (pwm_q < duty_q);
      pd_q  <= pe;
      if (en) pwm_q <= pwm_q + 1'b1;
      if (phase_chg) begin
        step_q <= '0;
      end else if (pe) begin
        step_q <= se ? '0 : step_q + 1'b1;
      end
      if (hold_adv) begin
        hold_q <= hold_end ? '0 : hold_q + 1'b1;
      end
      if (duty_inc) duty_q <= duty_q + 1'b1;
      if (duty_dec) duty_q <= duty_q - 1'b1;
    end
  end

  assign LED         = led_q;
  assign duty        = duty_q;
  assign phase       = phase_q;
  assign period_done = pd_q;

endmodule
